oport_uart_tx: RTL and testbench

//   Consumer end of the computer's 8-bit output port. Captures every byte the CPU

---
 rtl/oport_uart_tx_pkg.sv | 17 +
 rtl/oport_uart_tx_sync_fifo.sv | 52 +++++
 rtl/oport_uart_tx.sv | 147 ++++++++++++++
 tb/tb_oport_uart_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oport_uart_tx_pkg.sv
// Shared definitions for the output-port UART transmitter.
// FSM state encodings and 8N1 frame constants.
// No logic; imported by the transmitter top.
package oport_uart_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

endpackage

// File: rtl/oport_uart_tx_sync_fifo.sv
// Small synchronous FIFO with registered full/empty and occupancy count.
// Latency: a pushed entry is visible at pop_data the cycle after the push edge.
// No internal guarding: caller must never push when full without a pop, nor pop when empty.
module oport_uart_tx_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;

   assign count_nxt = count + CW'(push) - CW'(pop);
   assign pop_data  = mem[rd_ptr];

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers, occupancy and registered status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/oport_uart_tx.sv
// Captures CPU output-port writes into a FIFO and serialises them as 8N1 UART on tx.
// Latency: write at edge N into idle/empty -> start bit from edge N+1, frame ends at N+1+10*CLKS_PER_BIT.
// No backpressure to the CPU: writes arriving with the FIFO full and no pop are dropped and flag overflow.
module oport_uart_tx
   import oport_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] oport_data,
   input  logic       oport_we,
   input  logic       c_halt,
   output logic       tx,
   output logic       busy,
   output logic       fifo_full,
   output logic       overflow,
   output logic       drained
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   tx_state_t     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tx_d;
   logic          busy_d;
   logic          pop;
   logic          push;
   logic          baud_last;
   logic [7:0]    head;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_nxt;
   logic          fifo_empty;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push      = oport_we & (~fifo_full | pop);
   assign baud_last = (baud_q == BAUD_LAST);
   assign count_nxt = fifo_count + CW'(push) - CW'(pop);
   assign busy_d    = (state_d != ST_IDLE) | (count_nxt != '0);
   assign drained   = c_halt & ~busy;

   oport_uart_tx_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (oport_data),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Next-state, baud/bit counters, shifter and the registered line value.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = head;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         ST_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shreg_d = shreg_q >> 1;
               if (bit_q == BIT_LAST) state_d = ST_STOP;
               else                   bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         ST_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               // Chain straight into the next frame so bursts leave no idle gap.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_d = head;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      case (state_d)
         ST_START: tx_d = START_BIT;
         ST_DATA:  tx_d = shreg_d[0];
         default:  tx_d = STOP_BIT;
      endcase
   end

   // FSM state, counters and registered outputs; reset forces the line idle at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx      <= STOP_BIT;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx      <= tx_d;
         busy    <= busy_d;
      end
   end

   // Sticky drop flag, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                overflow <= 1'b0;
      else if (oport_we && !push) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_oport_uart_tx.sv
// Directed bench for oport_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A background UART decoder collects frames; each test task checks inline.
// Prints one summary line and finishes.
module tb_oport_uart_tx;

   logic       clk;
   logic       reset;
   logic [7:0] oport_data;
   logic       oport_we;
   logic       c_halt;
   logic       tx;
   logic       busy;
   logic       fifo_full;
   logic       overflow;
   logic       drained;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   oport_uart_tx #(
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .oport_data (oport_data),
      .oport_we   (oport_we),
      .c_halt     (c_halt),
      .tx         (tx),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .drained    (drained)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Frame decoder: k=1 is the first low sample; bit i centred at k=6+4i, stop at k=38.
   logic [7:0] rx_q[$];
   int         rx_start_q[$];
   int         rx_ferr = 0;
   int         rx_cnt  = 0;
   logic       rx_act  = 1'b0;
   logic [7:0] rx_sh   = '0;

   always @(negedge clk) begin
      if (!reset) begin
         rx_act <= 1'b0;
      end else if (!rx_act) begin
         if (tx === 1'b0) begin
            rx_act <= 1'b1;
            rx_cnt <= 1;
            rx_start_q.push_back(cyc);
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0)
            rx_sh <= {tx, rx_sh[7:1]};
         if (rx_cnt == 37) begin
            if (tx !== 1'b1) rx_ferr <= rx_ferr + 1;
            rx_q.push_back(rx_sh);
         end
         if (rx_cnt == 39) rx_act <= 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic write_byte(input logic [7:0] d);
      oport_data = d;
      oport_we   = 1'b1;
      @(negedge clk);
      oport_we   = 1'b0;
   endtask

   task automatic write_burst(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         oport_data = first + 8'(i);
         oport_we   = 1'b1;
         @(negedge clk);
      end
      oport_we = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int max, input string name);
      int n = 0;
      while (busy !== 1'b0 && n < max) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   task automatic test_reset();
      checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, required 0", fifo_full); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b, required 0", overflow); end
      checks++; if (drained !== 1'b0)   begin errors++; $display("FAIL reset_drained: got %b, required 0", drained); end
   endtask

   task automatic test_single_byte();
      logic [7:0] d = 8'hA5;
      logic       exp;
      write_byte(d);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_k0: got %b, required 1", busy); end
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k <= 4)       exp = 1'b0;
         else if (k <= 36) exp = d[(k - 5) / 4];
         else              exp = 1'b1;
         checks++;
         if (tx !== exp) begin errors++; $display("FAIL single_tx_k%0d: got %b, required %b", k, tx, exp); end
         checks++;
         if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_k%0d: got %b, required 1", k, busy); end
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b, required 0", busy); end
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL single_tx_idle: got %b, required 1", tx); end
   endtask

   task automatic test_burst();
      int base  = rx_q.size();
      int sbase = rx_start_q.size();
      int fe    = rx_ferr;
      write_burst(8'h01, 4);
      wait_idle(250, "burst");
      checks++;
      if (rx_q.size() != base + 4) begin errors++; $display("FAIL burst_count: got %0d frames, required 4", rx_q.size() - base); end
      for (int i = 0; i < 4 && base + i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[base + i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_byte%0d: got %h, required %h", i, rx_q[base + i], 8'(i + 1)); end
      end
      for (int i = 0; i < 3 && sbase + i + 1 < rx_start_q.size(); i++) begin
         checks++;
         if (rx_start_q[sbase + i + 1] - rx_start_q[sbase + i] != 40) begin
            errors++;
            $display("FAIL burst_gap%0d: got %0d cycles, required 40", i, rx_start_q[sbase + i + 1] - rx_start_q[sbase + i]);
         end
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf: got %b, required 0", overflow); end
      checks++; if (rx_ferr != fe)     begin errors++; $display("FAIL burst_stop: got %0d framing errors, required 0", rx_ferr - fe); end
   endtask

   task automatic test_overflow();
      int base = rx_q.size();
      write_burst(8'h11, 6);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow); end
      wait_idle(300, "ovf");
      checks++;
      if (rx_q.size() != base + 5) begin errors++; $display("FAIL ovf_count: got %0d frames, required 5", rx_q.size() - base); end
      for (int i = 0; i < 5 && base + i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[base + i] !== 8'h11 + 8'(i)) begin errors++; $display("FAIL ovf_byte%0d: got %h, required %h", i, rx_q[base + i], 8'h11 + 8'(i)); end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
   endtask

   task automatic test_full_pop();
      int base;
      int t0;
      apply_reset();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_rst_ovf: got %b, required 0", overflow); end
      base = rx_q.size();
      t0 = cyc + 1;
      write_burst(8'h21, 5);
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fullpop_full: got %b, required 1", fifo_full); end
      while (cyc < t0 + 40) @(negedge clk);
      write_byte(8'h26);
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL fullpop_ovf: got %b, required 0", overflow); end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fullpop_still_full: got %b, required 1", fifo_full); end
      wait_idle(320, "fullpop");
      checks++;
      if (rx_q.size() != base + 6) begin errors++; $display("FAIL fullpop_count: got %0d frames, required 6", rx_q.size() - base); end
      for (int i = 0; i < 6 && base + i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[base + i] !== 8'h21 + 8'(i)) begin errors++; $display("FAIL fullpop_byte%0d: got %h, required %h", i, rx_q[base + i], 8'h21 + 8'(i)); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int base = rx_q.size();
      int fe   = rx_ferr;
      write_byte(8'h5A);
      write_byte(8'h77);
      repeat (17) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL midrst_tx: got %b, required 1", tx); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b, required 0", fifo_full); end
      @(negedge clk);
      oport_data = 8'h99;
      oport_we   = 1'b1;
      repeat (2) @(negedge clk);
      oport_we = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_we_ignored: busy=%b, required 0", busy); end
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL midrst_tx_after: got %b, required 1", tx); end
      write_byte(8'h3C);
      wait_idle(80, "midrst");
      checks++;
      if (rx_q.size() != base + 1) begin
         errors++; $display("FAIL midrst_count: got %0d frames, required 1", rx_q.size() - base);
      end else begin
         checks++;
         if (rx_q[base] !== 8'h3C) begin errors++; $display("FAIL midrst_byte: got %h, required 3c", rx_q[base]); end
      end
      checks++; if (rx_ferr != fe) begin errors++; $display("FAIL midrst_stop: got %0d framing errors, required 0", rx_ferr - fe); end
   endtask

   task automatic test_drain();
      write_byte(8'hFF);
      @(negedge clk);
      @(negedge clk);
      c_halt = 1'b1;
      #1;
      checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_k2: got %b, required 0", drained); end
      for (int k = 3; k <= 40; k++) begin
         @(negedge clk);
         checks++;
         if (drained !== 1'b0) begin errors++; $display("FAIL drain_k%0d: got %b, required 0", k, drained); end
      end
      @(negedge clk);
      checks++; if (drained !== 1'b1) begin errors++; $display("FAIL drain_end: got %b, required 1", drained); end
      c_halt = 1'b0;
      #1;
      checks++; if (drained !== 1'b0) begin errors++; $display("FAIL drain_unhalt: got %b, required 0", drained); end
   endtask

   initial begin
      reset      = 1'b0;
      oport_we   = 1'b0;
      oport_data = 8'h00;
      c_halt     = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      test_single_byte();
      @(negedge clk);
      test_burst();
      @(negedge clk);
      test_overflow();
      @(negedge clk);
      test_full_pop();
      @(negedge clk);
      test_reset_mid_frame();
      @(negedge clk);
      test_drain();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
